// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the register-file write arbiter and its pipeline/MC/Decode clients.
interface rf_write_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Pipeline writeback
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_stall;

    // Multi-cycle unit results
    logic            mc_valid;
    logic [AW-1:0]   mc_rd;
    logic [XLEN-1:0] mc_data;
    logic            mc_ready;

    // Register file write port
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    // Decode hazard lookup
    logic [AW-1:0]   q_rs1;
    logic [AW-1:0]   q_rs2;
    logic            q_hit1;
    logic            q_hit2;
    logic [CW-1:0]   mc_pending;

    modport slave (
        input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, q_rs1, q_rs2,
        output wb_stall, mc_ready, rf_we, rf_waddr, rf_wdata, q_hit1, q_hit2, mc_pending
    );

    modport master (
        output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, q_rs1, q_rs2,
        input  wb_stall, mc_ready, rf_we, rf_waddr, rf_wdata, q_hit1, q_hit2, mc_pending
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline WB and buffered MC results,
// with bounded-wait forced grants for the MC FIFO head and a pending-rd lookup.
module rf_write_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [AW-1:0]   mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [WW-1:0]   wait_nxt;

    logic            mc_ready;
    logic            push_store;
    logic            wb_real;
    logic            nonempty;
    logic            pop;
    logic            rf_we;
    logic            wb_stall;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            hit1;
    logic            hit2;

    // Handshake and grant decisions; nothing is granted or stored while in reset.
    always_comb begin
        mc_ready   = (count < CW'(DEPTH));
        push_store = !rst && bus.mc_valid && mc_ready && (bus.mc_rd != '0);
        wb_real    = bus.wb_valid && (bus.wb_rd != '0);
        nonempty   = (count != '0);
        pop        = !rst && nonempty && (!wb_real || (wait_cnt == WW'(MAX_WAIT)));
        rf_we      = pop || (!rst && wb_real);
        wb_stall   = pop && wb_real;
        rf_waddr   = pop ? mem_rd[rd_ptr]   : bus.wb_rd;
        rf_wdata   = pop ? mem_data[rd_ptr] : bus.wb_data;
    end

    // Occupancy and starvation-counter next state.
    always_comb begin
        count_nxt = count;
        case ({push_store, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        wait_nxt = wait_cnt;
        if (pop || !nonempty) begin
            wait_nxt = '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + WW'(1);
        end
    end

    // FIFO storage, pointers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PW'(1);
            end
            if (push_store) begin
                mem_rd[wr_ptr]   <= bus.mc_rd;
                mem_data[wr_ptr] <= bus.mc_data;
                vld[wr_ptr]      <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // RAW lookup against stored entries only; the entry popping this cycle still counts.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld[i] && (mem_rd[i] == bus.q_rs1)) hit1 = 1'b1;
            if (vld[i] && (mem_rd[i] == bus.q_rs2)) hit2 = 1'b1;
        end
        if (bus.q_rs1 == '0) hit1 = 1'b0;
        if (bus.q_rs2 == '0) hit2 = 1'b0;
    end

    assign bus.mc_ready   = mc_ready;
    assign bus.wb_stall   = wb_stall;
    assign bus.rf_we      = rf_we;
    assign bus.rf_waddr   = rf_waddr;
    assign bus.rf_wdata   = rf_wdata;
    assign bus.q_hit1     = hit1;
    assign bus.q_hit2     = hit2;
    assign bus.mc_pending = count;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rf_write_arbiter_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) bus ();

    rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic exp_write(input string tag, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                             input logic stall);
        check({tag, "_we"},    64'(bus.rf_we), 64'(1));
        check({tag, "_waddr"}, 64'(bus.rf_waddr), 64'(a));
        check({tag, "_wdata"}, 64'(bus.rf_wdata), 64'(d));
        check({tag, "_stall"}, 64'(bus.wb_stall), 64'(stall));
    endtask

    task automatic mc_push(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.mc_valid = 1'b1;
        bus.mc_rd    = rd;
        bus.mc_data  = d;
    endtask

    initial begin
        rst          = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.mc_valid = 1'b0;
        bus.mc_rd    = '0;
        bus.mc_data  = '0;
        bus.q_rs1    = '0;
        bus.q_rs2    = '0;
        step();
        step();
        rst = 1'b0;
        settle();
        check("rst_we",      64'(bus.rf_we), 64'(0));
        check("rst_stall",   64'(bus.wb_stall), 64'(0));
        check("rst_ready",   64'(bus.mc_ready), 64'(1));
        check("rst_pending", 64'(bus.mc_pending), 64'(0));
        check("rst_hit1",    64'(bus.q_hit1), 64'(0));
        check("rst_hit2",    64'(bus.q_hit2), 64'(0));

        // 1: idle WB, MC result drains one cycle after push
        mc_push(5'd5, 32'hDEADBEEF);
        settle();
        check("t1_nobypass", 64'(bus.rf_we), 64'(0));
        step();
        bus.mc_valid = 1'b0;
        settle();
        check("t1_pending1", 64'(bus.mc_pending), 64'(1));
        exp_write("t1_drain", 5'd5, 32'hDEADBEEF, 1'b0);
        step();
        settle();
        check("t1_pending0", 64'(bus.mc_pending), 64'(0));
        check("t1_idle_we",  64'(bus.rf_we), 64'(0));

        // 2: busy WB starves MC for 4 eligible cycles, then forced grant
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd1;
        bus.wb_data  = 32'h100;
        mc_push(5'd7, 32'h77);
        settle();
        exp_write("t2_wb0", 5'd1, 32'h100, 1'b0);
        step();
        bus.mc_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.wb_rd   = AW'(i + 1);
            bus.wb_data = 32'h100 + XLEN'(i);
            settle();
            exp_write($sformatf("t2_wb%0d", i), AW'(i + 1), 32'h100 + XLEN'(i), 1'b0);
            step();
        end
        bus.wb_rd   = 5'd6;
        bus.wb_data = 32'h106;
        settle();
        exp_write("t2_forced", 5'd7, 32'h77, 1'b1);
        step();
        settle();
        exp_write("t2_held", 5'd6, 32'h106, 1'b0);
        check("t2_pending", 64'(bus.mc_pending), 64'(0));

        // 3: FIFO fills, MC back-pressured until forced pop frees a slot
        bus.wb_rd   = 5'd10;
        bus.wb_data = 32'hA;
        step();
        mc_push(5'd3, 32'h33);
        step();
        mc_push(5'd4, 32'h44);
        settle();
        check("t3_pend1",  64'(bus.mc_pending), 64'(1));
        check("t3_ready1", 64'(bus.mc_ready), 64'(1));
        step();
        mc_push(5'd8, 32'h88);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t3_full_pend%0d", i),  64'(bus.mc_pending), 64'(2));
            check($sformatf("t3_full_ready%0d", i), 64'(bus.mc_ready), 64'(0));
            exp_write($sformatf("t3_wb%0d", i), 5'd10, 32'hA, 1'b0);
            step();
        end
        settle();
        check("t3_forced_ready", 64'(bus.mc_ready), 64'(0));
        exp_write("t3_forced", 5'd3, 32'h33, 1'b1);
        step();
        settle();
        check("t3_after_ready", 64'(bus.mc_ready), 64'(1));
        check("t3_after_pend",  64'(bus.mc_pending), 64'(1));
        exp_write("t3_wb_resume", 5'd10, 32'hA, 1'b0);
        step();
        bus.mc_valid = 1'b0;
        bus.wb_valid = 1'b0;
        settle();
        check("t3_pend2", 64'(bus.mc_pending), 64'(2));
        exp_write("t3_drain4", 5'd4, 32'h44, 1'b0);
        step();
        settle();
        exp_write("t3_drain8", 5'd8, 32'h88, 1'b0);
        step();
        settle();
        check("t3_empty", 64'(bus.mc_pending), 64'(0));

        // 4: WB to x0 never stalls; MC push to x0 is discarded
        mc_push(5'd6, 32'h66);
        step();
        bus.mc_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'hBAD;
        settle();
        exp_write("t4_x0wb", 5'd6, 32'h66, 1'b0);
        step();
        bus.wb_valid = 1'b0;
        mc_push(5'd0, 32'h99);
        settle();
        check("t4_x0_ready", 64'(bus.mc_ready), 64'(1));
        step();
        bus.mc_valid = 1'b0;
        settle();
        check("t4_x0_pend", 64'(bus.mc_pending), 64'(0));
        check("t4_x0_we",   64'(bus.rf_we), 64'(0));

        // 5: pending-destination lookup, including during the pop cycle
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd2;
        bus.wb_data  = 32'h22;
        mc_push(5'd9, 32'h9);
        step();
        bus.mc_valid = 1'b0;
        bus.q_rs1    = 5'd9;
        bus.q_rs2    = 5'd0;
        settle();
        check("t5_hit1", 64'(bus.q_hit1), 64'(1));
        check("t5_hit2", 64'(bus.q_hit2), 64'(0));
        bus.q_rs2 = 5'd2;
        settle();
        check("t5_hit2_wbrd", 64'(bus.q_hit2), 64'(0));
        bus.wb_valid = 1'b0;
        settle();
        exp_write("t5_pop", 5'd9, 32'h9, 1'b0);
        check("t5_hit1_popcyc", 64'(bus.q_hit1), 64'(1));
        step();
        settle();
        check("t5_hit1_after", 64'(bus.q_hit1), 64'(0));

        // 6: reset with a full FIFO and a nearly expired wait counter
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd11;
        bus.wb_data  = 32'hB;
        mc_push(5'd12, 32'hC);
        step();
        mc_push(5'd13, 32'hD);
        step();
        bus.mc_valid = 1'b0;
        step();
        step();
        settle();
        check("t6_pre_pend", 64'(bus.mc_pending), 64'(2));
        rst = 1'b1;
        settle();
        check("t6_rst_we", 64'(bus.rf_we), 64'(0));
        step();
        rst          = 1'b0;
        bus.wb_valid = 1'b0;
        bus.q_rs1    = 5'd12;
        bus.q_rs2    = 5'd13;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t6_pend%0d", i),  64'(bus.mc_pending), 64'(0));
            check($sformatf("t6_we%0d", i),    64'(bus.rf_we), 64'(0));
            check($sformatf("t6_ready%0d", i), 64'(bus.mc_ready), 64'(1));
            check($sformatf("t6_hit1_%0d", i), 64'(bus.q_hit1), 64'(0));
            check($sformatf("t6_hit2_%0d", i), 64'(bus.q_hit2), 64'(0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
